uart_fifo: RTL and testbench
============================

Name: uart_fifo

Overview:
Synchronous first-word-fall-through (FWFT) byte FIFO.
- TX instance: sits directly downstream of the APB register interface. tx_fifo_wen/tx_fifo_wdata drive the write side; the TX serializer drains the read side.
- RX instance: the same module. The RX deserializer drives the write side; the register interface's rx_fifo_ren pops the read side within the same APB access cycle.
- Provides full/empty, occupancy count, a programmable level flag and sticky overflow/underflow flags for the status register group.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; power of two, ≥ 2.
- CNT_W, $clog2(DEPTH)+1, width of the count and threshold ports (derived, not overridden).

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- clr_i  in  1  synchronous flush; also clears the sticky flags.
- wen_i  in  1  write strobe; one word per asserted cycle.
- wdata_i  in  WIDTH  write data.
- ren_i  in  1  read/pop strobe; one word per asserted cycle.
- rdata_o  out  WIDTH  head word, valid combinationally while !empty_o.
- empty_o  out  1  count == 0.
- full_o  out  1  count == DEPTH.
- count_o  out  CNT_W  occupancy, 0..DEPTH.
- thresh_i  in  CNT_W  level threshold.
- level_o  out  1  count_o ≥ thresh_i.
- overflow_o  out  1  sticky: a write was attempted while full.
- underflow_o  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (reset_i low, asynchronous):
  - wptr = rptr = 0, count = 0.
  - empty_o = 1, full_o = 0.
  - overflow_o = 0, underflow_o = 0.
  - rdata_o = 0.
  - level_o = (thresh_i == 0).
  - Storage array is not reset.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is a separate CNT_W-bit register.
- Priority each cycle: clr_i > normal operation. With clr_i = 1:
  - pointers and count go to 0, sticky flags go to 0;
  - wen_i and ren_i are ignored that cycle.
- Write accept: wen_i && !full_o || wen_i && ren_i && full_o.
  - Accepted: mem[wptr] <= wdata_i, wptr increments.
  - Not accepted: data is dropped and overflow_o is set the next cycle.
- Read accept: ren_i && !empty_o.
  - Accepted: rptr increments.
  - ren_i while empty: no pointer change and underflow_o is set the next cycle.
- FWFT timing: rdata_o = mem[rptr] when !empty_o, else 0.
  - A word written in cycle N appears on rdata_o in cycle N+1.
  - There is no write-to-read bypass while empty.
- count update: +1 on write-only accept, −1 on read-only accept, unchanged when both accept or neither.
- Simultaneous write and read:
  - Full: both accepted, count stays DEPTH, no overflow.
  - Empty: write accepted, read rejected and underflow set; count becomes 1.
- empty_o, full_o and level_o are combinational from the count register, so they update the cycle after the causing edge.
- Sticky flags hold until clr_i or reset.
- Reset asserted mid-operation discards contents immediately; no partial state survives.

Decomposition:
- uart_reg_pkg gains:
  - UART_FIFO_DEPTH (16) and UART_FIFO_WIDTH (8) constants;
  - a fifo_status_t packed struct {empty, full, level, overflow, underflow, count}, so both FIFO instances map directly into status_reg_t.
- Sub-module uart_fifo_mem holds the storage array: DEPTH×WIDTH registers, one synchronous write port, one combinational read port, no reset.
- uart_fifo holds the pointers, count, flags and control.

Test Plan (DEPTH=16, WIDTH=8):
- Reset then idle → empty_o=1, full_o=0, count_o=0, rdata_o=0x00, flags 0. With thresh_i=0: level_o=1.
- Write 0x11..0x20 (16 words), then attempt 0xAA → full_o=1, count_o=16, overflow_o=1. Drain 16 reads → 0x11..0x20 in order, 0xAA never seen, empty_o=1.
- Fill to 16, then wen+ren in the same cycle with 0x55 → count_o stays 16, overflow_o=0. After 15 further reads the head is 0x55. Confirms pointer wraparound.
- Empty FIFO, wen 0x3C + ren in the same cycle → underflow_o=1, count_o=1, rdata_o=0x3C next cycle.
- thresh_i=4, write 3 words → level_o=0. Write a 4th → level_o=1. Read 1 → level_o=0.
- Write 5 words, pulse clr_i together with wen_i → count_o=0, flags clear, the concurrent write is discarded. Separately, assert reset_i low mid-burst → outputs return to reset values asynchronously.

Source files
------------

// File: rtl/uart_reg_pkg.sv
// Shared UART register-interface definitions: FIFO sizing constants and the
// per-FIFO status word that both the TX and RX instances map into the status registers.
package uart_reg_pkg;

    localparam int UART_FIFO_DEPTH = 16;
    localparam int UART_FIFO_WIDTH = 8;
    localparam int UART_FIFO_CNT_W = $clog2(UART_FIFO_DEPTH) + 1;

    typedef struct packed {
        logic                       empty;
        logic                       full;
        logic                       level;
        logic                       overflow;
        logic                       underflow;
        logic [UART_FIFO_CNT_W-1:0] count;
    } fifo_status_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for uart_fifo: one synchronous write port, one combinational
// read port, deliberately left unreset.
module uart_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_fifo.sv
// First-word-fall-through byte FIFO shared by the UART TX and RX paths, with
// occupancy count, programmable level flag and sticky overflow/underflow flags.
module uart_fifo
    import uart_reg_pkg::*;
#(
    parameter int  WIDTH = UART_FIFO_WIDTH,
    parameter int  DEPTH = UART_FIFO_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             wen_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             ren_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o,
    input  logic [CNT_W-1:0] thresh_i,
    output logic             level_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] mem_rdata;

    // A full FIFO can still take a write when the same cycle pops the head.
    always_comb begin
        wr_acc      = !clr_i && wen_i && (!full_o || ren_i);
        rd_acc      = !clr_i && ren_i && !empty_o;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_i) begin
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + 1'b1;
            if (rd_acc) rptr_d = rptr_q + 1'b1;
            if (wr_acc && !rd_acc) count_d = count_q + 1'b1;
            if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
            overflow_d  = overflow_q  || (wen_i && !wr_acc);
            underflow_d = underflow_q || (ren_i && empty_o);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    uart_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_acc),
        .waddr_i (wptr_q),
        .wdata_i (wdata_i),
        .raddr_i (rptr_q),
        .rdata_o (mem_rdata)
    );

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign level_o     = (count_q >= thresh_i);
    assign count_o     = count_q;
    assign rdata_o     = empty_o ? '0 : mem_rdata;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: a queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_uart_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b0;
    logic             clr_i = 1'b0;
    logic             wen_i = 1'b0;
    logic [WIDTH-1:0] wdata_i = '0;
    logic             ren_i = 1'b0;
    logic [CNT_W-1:0] thresh_i = '0;
    logic [WIDTH-1:0] rdata_o;
    logic             empty_o, full_o, level_o, overflow_o, underflow_o;
    logic [CNT_W-1:0] count_o;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model_q[$];
    bit               model_ovf = 1'b0;
    bit               model_unf = 1'b0;
    bit               m_wr, m_rd;

    uart_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clr_i       (clr_i),
        .wen_i       (wen_i),
        .wdata_i     (wdata_i),
        .ren_i       (ren_i),
        .rdata_o     (rdata_o),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .count_o     (count_o),
        .thresh_i    (thresh_i),
        .level_o     (level_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and return just after the edge that consumes them.
    task automatic apply_stimulus(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit c);
        wen_i   = w;
        wdata_i = d;
        ren_i   = r;
        clr_i   = c;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Reference model: an ordinary queue holding the stored words in order.
    always @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            model_q.delete();
            model_ovf = 1'b0;
            model_unf = 1'b0;
        end else if (clr_i) begin
            model_q.delete();
            model_ovf = 1'b0;
            model_unf = 1'b0;
        end else begin
            m_rd = ren_i && (model_q.size() > 0);
            m_wr = wen_i && ((model_q.size() < DEPTH) || ren_i);
            if (wen_i && !m_wr) model_ovf = 1'b1;
            if (ren_i && model_q.size() == 0) model_unf = 1'b1;
            if (m_rd) void'(model_q.pop_front());
            if (m_wr) model_q.push_back(wdata_i);
        end
    end

    always @(negedge clk_i) begin
        check_output("m_empty", empty_o, model_q.size() == 0);
        check_output("m_full", full_o, model_q.size() == DEPTH);
        check_output("m_count", count_o, model_q.size());
        check_output("m_rdata", rdata_o, (model_q.size() > 0) ? model_q[0] : 8'h00);
        check_output("m_level", level_o, model_q.size() >= int'(thresh_i));
        check_output("m_overflow", overflow_o, model_ovf);
        check_output("m_underflow", underflow_o, model_unf);
    end

    initial begin
        #3;
        check_output("rst_empty", empty_o, 1);
        check_output("rst_full", full_o, 0);
        check_output("rst_count", count_o, 0);
        check_output("rst_rdata", rdata_o, 8'h00);
        check_output("rst_ovf", overflow_o, 0);
        check_output("rst_unf", underflow_o, 0);
        check_output("rst_level", level_o, 1);
        #9 reset_i = 1'b1;
        idle();
        idle();
        check_output("idle_empty", empty_o, 1);
        check_output("idle_count", count_o, 0);

        for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        idle();
        check_output("fill_full", full_o, 1);
        check_output("fill_count", count_o, 16);
        check_output("fill_ovf", overflow_o, 1);
        for (int i = 0; i < 16; i++) begin
            check_output("drain_data", rdata_o, 8'h11 + i);
            apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check_output("drain_empty", empty_o, 1);
        check_output("drain_unf", underflow_o, 0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        check_output("clr_ovf", overflow_o, 0);

        for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h55, 1'b1, 1'b0);
        check_output("rw_full_count", count_o, 16);
        check_output("rw_full_ovf", overflow_o, 0);
        check_output("rw_full_head", rdata_o, 8'h61);
        for (int i = 0; i < 15; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check_output("wrap_head", rdata_o, 8'h55);
        check_output("wrap_count", count_o, 1);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check_output("wrap_empty", empty_o, 1);

        apply_stimulus(1'b1, 8'h3C, 1'b1, 1'b0);
        check_output("rw_empty_unf", underflow_o, 1);
        check_output("rw_empty_count", count_o, 1);
        check_output("rw_empty_data", rdata_o, 8'h3C);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);

        thresh_i = 5'd4;
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        check_output("lvl_3", level_o, 0);
        apply_stimulus(1'b1, 8'hA3, 1'b0, 1'b0);
        check_output("lvl_4", level_o, 1);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check_output("lvl_read", level_o, 0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);

        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check_output("pre_clr_unf", underflow_o, 1);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h99, 1'b0, 1'b1);
        check_output("clr_count", count_o, 0);
        check_output("clr_unf", underflow_o, 0);
        check_output("clr_empty", empty_o, 1);
        apply_stimulus(1'b1, 8'h77, 1'b0, 1'b0);
        idle();
        check_output("post_clr_head", rdata_o, 8'h77);
        check_output("post_clr_count", count_o, 1);

        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
        #2 reset_i = 1'b0;
        #1;
        check_output("async_empty", empty_o, 1);
        check_output("async_count", count_o, 0);
        check_output("async_rdata", rdata_o, 8'h00);
        check_output("async_level", level_o, 0);
        apply_stimulus(1'b1, 8'hEE, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'hEF, 1'b0, 1'b0);
        check_output("held_count", count_o, 0);
        wen_i = 1'b0;
        #2 reset_i = 1'b1;
        idle();
        idle();
        check_output("after_rst_empty", empty_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
